// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared state encoding and counter width for the shift sequencer
package shift_seq_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, GAP} sseq_state_t;
  localparam int CNT_W = 4;
endpackage

// File: rtl/sseq_piso.sv
// sseq_piso: right-shift parallel-load register presenting its LSB on q
module sseq_piso #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clrb,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  output logic         q
);
  logic [W-1:0] shreg;
  // load wins over shift; zeros enter at the top so a fully shifted register drives 0
  always_ff @(posedge clk or negedge clrb)
    if (!clrb) shreg <= '0;
    else if (load) shreg <= load_data;
    else if (shift_en) shreg <= {1'b0, shreg[W-1:1]};
  assign q = shreg[0];
endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: accepts a word over valid/ready and shifts it out LSB-first with done pulse and inter-word gap
// Build option SHIFT_SEQ_PARITY_EN appends an even-parity bit after the data bits.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int GAP = 1
) (
  input  logic             clk,
  input  logic             clrb,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             busy,
  output logic             done
);
`ifdef SHIFT_SEQ_PARITY_EN
  localparam logic PARITY = 1'b1;
  localparam int PW = WIDTH + 1;
  logic [PW-1:0] frame;
  assign frame = {^load_data, load_data};
`else
  localparam logic PARITY = 1'b0;
  localparam int PW = WIDTH;
  logic [PW-1:0] frame;
  assign frame = load_data;
`endif
  localparam sseq_state_t AFTER = (GAP == 0) ? IDLE : shift_seq_pkg::GAP;
  sseq_state_t state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic accept, last_bit, gap_end, frame_end;
  assign accept = load_valid && load_ready;
  assign last_bit = state == SHIFT && cnt == CNT_W'(WIDTH - 1);
  assign gap_end = state == shift_seq_pkg::GAP && cnt == CNT_W'(GAP - 1);
  assign frame_end = PARITY ? state == PAR : last_bit;
  // the parity bit rides in the top of the shift register, so sdo is always the register LSB
  sseq_piso #(.W(PW)) u_piso (
    .clk(clk),
    .clrb(clrb),
    .load(accept),
    .load_data(frame),
    .shift_en(state == SHIFT || state == PAR),
    .q(sdo)
  );
  // next state; the counter restarts on every state change and holds at zero in IDLE
  always_comb begin
    nxt = state;
    if (state == IDLE && accept) nxt = SHIFT;
    else if (last_bit) nxt = PARITY ? PAR : AFTER;
    else if (state == PAR) nxt = AFTER;
    else if (gap_end) nxt = IDLE;
    cnt_nxt = (nxt != state || state == IDLE) ? '0 : cnt + 1'b1;
  end
  // state and flags registered from the next state so every output is a flop
  always_ff @(posedge clk or negedge clrb)
    if (!clrb) begin
      state <= IDLE;
      cnt <= '0;
      load_ready <= 1'b0;
      sdo_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      load_ready <= nxt == IDLE;
      sdo_valid <= nxt == SHIFT || nxt == PAR;
      busy <= nxt != IDLE;
      done <= frame_end;
    end
endmodule
